// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage constants, state enum and buffer entry type
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/riscv_fetch_stage_if.sv
// rtl/riscv_fetch_stage_if.sv - instruction memory request/response port
interface riscv_fetch_stage_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/riscv_fetch_buf.sv
// rtl/riscv_fetch_buf.sv - fetched-instruction holding register, or 2-entry FIFO when INST_BUF_EN is defined
module riscv_fetch_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

`ifdef INST_BUF_EN
    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == 2'd0);
    assign full  = (cnt == 2'd2);
`else
    fetch_entry_t hold;
    logic         hold_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) hold <= push_entry;
    end

    assign head  = hold;
    assign empty = !hold_valid;
    assign full  = hold_valid;
`endif

endmodule

// File: rtl/riscv_fetch_stage.sv
// rtl/riscv_fetch_stage.sv - PC, imem request FSM and IF/ID register; INST_BUF_EN enables 2-deep fetch buffering
module riscv_fetch_stage
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                redirect_valid_i,
    input  logic [31:0]         redirect_pc_i,
    riscv_fetch_stage_if.master imem,
    output logic                if_id_valid_o,
    output logic [31:0]         if_id_pc_o,
    output logic [31:0]         if_id_pc4_o,
    output logic [31:0]         if_id_inst_o
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         req_valid;
    logic         req_fire;
    logic         rsp_take;
    logic         direct;
    logic         push;
    logic         pop;
    logic         buf_empty;
    logic         buf_full;
    fetch_entry_t buf_head;
    fetch_entry_t rsp_entry;

    assign rsp_entry = '{pc: req_pc, inst: imem.rsp_data};

    // A response goes straight to IF/ID only when nothing older is queued ahead of it.
    always_comb begin
        rsp_take = (state == WAIT) && imem.rsp_valid && !redirect_valid_i;
        pop      = !stall_i && !redirect_valid_i && !buf_empty;
        direct   = rsp_take && !stall_i && buf_empty;
        push     = rsp_take && !direct;
    end

`ifdef INST_BUF_EN
    logic [1:0] occ_next;

    // Occupancy after this cycle's push/pop; a request may overlap a returning response.
    always_comb begin
        occ_next  = {buf_full, !buf_full && !buf_empty} + {1'b0, push} - {1'b0, pop};
        req_valid = ((state == REQ) || ((state == WAIT) && imem.rsp_valid))
                    && (occ_next < 2'd2);
    end
`else
    always_comb begin
        req_valid = (state == REQ) && !buf_full;
    end
`endif

    assign req_fire       = req_valid && imem.req_ready;
    assign imem.req_valid = req_valid;
    assign imem.addr      = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // A request accepted in a redirect cycle belongs to the flushed path.
    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                if (req_fire) state_nxt = redirect_valid_i ? DRAIN : WAIT;
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    if (req_fire) state_nxt = redirect_valid_i ? DRAIN : WAIT;
                    else          state_nxt = REQ;
                end else if (redirect_valid_i) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem.rsp_valid) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (redirect_valid_i) begin
                pc <= word_align(redirect_pc_i);
            end else if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (req_fire) req_pc <= pc;
        end
    end

    riscv_fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid_i),
        .push       (push),
        .push_entry (rsp_entry),
        .pop        (pop),
        .head       (buf_head),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    always_ff @(posedge clk) begin
        if (rst || redirect_valid_i) begin
            if_id_valid_o <= 1'b0;
            if_id_pc_o    <= 32'd0;
            if_id_pc4_o   <= 32'd0;
            if_id_inst_o  <= NOP_INST;
        end else if (!stall_i) begin
            if (pop) begin
                if_id_valid_o <= 1'b1;
                if_id_pc_o    <= buf_head.pc;
                if_id_pc4_o   <= buf_head.pc + 32'd4;
                if_id_inst_o  <= buf_head.inst;
            end else if (direct) begin
                if_id_valid_o <= 1'b1;
                if_id_pc_o    <= req_pc;
                if_id_pc4_o   <= req_pc + 32'd4;
                if_id_inst_o  <= imem.rsp_data;
            end else begin
                if_id_valid_o <= 1'b0;
                if_id_pc_o    <= 32'd0;
                if_id_pc4_o   <= 32'd0;
                if_id_inst_o  <= NOP_INST;
            end
        end
    end

endmodule
